mmio_uart_ctrl: RTL and testbench

// - Parametrised successor MMIO UART: on-chip sync FIFOs of configurable depth,

---
 rtl/mmio_uart_ctrl_pkg.sv | 42 ++++
 rtl/mmio_uart_ctrl_fifo.sv | 53 +++++
 rtl/mmio_uart_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared definitions for the MMIO UART controller: register offsets
// (addr[4:2]), STATUS/CTRL bit positions, TX/RX FSM state types and the
// baud divisor floor.
package mmio_uart_ctrl_pkg;

    // Register offsets, word index within the 32-byte window
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_BAUD   = 3'd4;
    localparam logic [2:0] REG_CLEAR  = 3'd5;

    // STATUS bit positions; [7:5] are the sticky error bits
    localparam int unsigned ST_RX_VALID  = 0;
    localparam int unsigned ST_RX_FULL   = 1;
    localparam int unsigned ST_TX_EMPTY  = 2;
    localparam int unsigned ST_TX_FULL   = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_RX_OVR    = 5;
    localparam int unsigned ST_FRAME_ERR = 6;
    localparam int unsigned ST_TX_OVF    = 7;

    // CTRL bit positions
    localparam int unsigned CTRL_TX_EN     = 0;
    localparam int unsigned CTRL_RX_EN     = 1;
    localparam int unsigned CTRL_IRQ_RX    = 2;
    localparam int unsigned CTRL_IRQ_TXE   = 3;
    localparam int unsigned CTRL_LOOPBACK  = 4;

    localparam logic [4:0]  CTRL_RESET = 5'b00011;
    localparam logic [15:0] BAUD_MIN   = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Divisors below the floor would leave no room for mid-bit sampling
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < BAUD_MIN) ? BAUD_MIN : d;
    endfunction

endpackage

// File: rtl/mmio_uart_ctrl_fifo.sv
// uart_sync_fifo: single-clock FIFO with count-based full/empty and a
// first-word-fall-through output (dout_o shows the head entry while !empty_o).
// Ports: clk_i, rst_ni (async active-low), push_i/din_i, pop_i, dout_o,
// full_o, empty_o. A push while full succeeds only if a pop happens in the
// same cycle; a pop while empty is ignored.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MMIO UART with TX/RX FIFOs, runtime baud divisor, sticky
// error bits, internal loopback and a registered level interrupt.
// Ports: sys_clk, rst_n (async active-low); mmio_read/mmio_write/mmio_addr/
// mmio_write_data request in; mmio_work (comb decode), mmio_done (1-cycle
// pulse), mmio_read_data (valid with done, else 0); uart_rx_pin in,
// uart_tx_pin out (idle high); irq level out.
module mmio_uart_ctrl
    import mmio_uart_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0140,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        mmio_read,
    input  logic        mmio_write,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_write_data,
    output logic        mmio_work,
    output logic        mmio_done,
    output logic [31:0] mmio_read_data,
    input  logic        uart_rx_pin,
    output logic        uart_tx_pin,
    output logic        irq
);
    // Bus / register state
    logic        done_q;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  sticky_q, sticky_d;   // {tx_overflow, frame_err, rx_overrun}
    logic        irq_q, irq_d;
    logic        accept, wr, rd;
    logic [2:0]  sel;
    logic [31:0] status;

    // FIFO interface
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;

    // TX path
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_load, tx_line, tx_ovf_set;

    // RX path
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_src, rx_sync1_q, rx_sync2_q, rx_prev_q, rx_fall;
    logic        rx_ovr_set, frame_set;

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[1:0], mmio_write_data[31:16]};

    // ---------------- bus decode ----------------
    assign mmio_work = (mmio_read || mmio_write) && (mmio_addr[31:5] == BASE_ADDR[31:5]);
    assign accept    = mmio_work && !done_q;
    assign wr        = accept && mmio_write;
    assign rd        = accept && mmio_read;
    assign sel       = mmio_addr[4:2];

    assign mmio_done      = done_q;
    assign mmio_read_data = rdata_q;
    assign irq            = irq_q;

    assign tx_push    = wr && (sel == REG_TXDATA);
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_pop     = rd && (sel == REG_RXDATA) && !rx_empty;
    assign rx_ovr_set = rx_push && rx_full && !rx_pop;

    always_comb begin
        status = '0;
        status[ST_RX_VALID] = !rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_BUSY]  = (tx_state_q != TX_IDLE);
        status[7:5]         = sticky_q;
    end

    always_comb begin
        rdata_d  = '0;
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        sticky_d = sticky_q;
        if (rd) begin
            case (sel)
                REG_STATUS: rdata_d = status;
                REG_RXDATA: rdata_d = rx_empty ? '0 : {24'd0, rx_dout};
                REG_CTRL:   rdata_d = {27'd0, ctrl_q};
                REG_BAUD:   rdata_d = {16'd0, div_q};
                default:    rdata_d = '0;
            endcase
        end
        if (wr && sel == REG_CTRL)  ctrl_d = mmio_write_data[4:0];
        if (wr && sel == REG_BAUD)  div_d  = clamp_div(mmio_write_data[15:0]);
        if (wr && sel == REG_CLEAR) sticky_d = sticky_q & ~mmio_write_data[7:5];
        // Applied after CLEAR so a same-cycle set survives
        sticky_d = sticky_d | {tx_ovf_set, frame_set, rx_ovr_set};
        irq_d = (ctrl_q[CTRL_IRQ_RX] && !rx_empty)
              || (ctrl_q[CTRL_IRQ_TXE] && tx_empty && tx_state_q == TX_IDLE)
              || (|sticky_q);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            rdata_q  <= '0;
            ctrl_q   <= CTRL_RESET;
            div_q    <= DIV_RESET;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            done_q   <= accept;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    // ---------------- FIFOs ----------------
    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i  (sys_clk),
        .rst_ni (rst_n),
        .push_i (tx_push),
        .din_i  (mmio_write_data[7:0]),
        .pop_i  (tx_pop),
        .dout_o (tx_dout),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i  (sys_clk),
        .rst_ni (rst_n),
        .push_i (rx_push),
        .din_i  (rx_shift_q),
        .pop_i  (rx_pop),
        .dout_o (rx_dout),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    // ---------------- TX FSM ----------------
    always_comb begin
        case (tx_state_q)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_shift_q[0];
            default:  tx_line = 1'b1;
        endcase
    end

    assign uart_tx_pin = ctrl_q[CTRL_LOOPBACK] | tx_line;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: tx_load = ctrl_q[CTRL_TX_EN] && !tx_empty;
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_IDLE;
                    // Chain straight into the next start bit, no idle gap
                    tx_load    = ctrl_q[CTRL_TX_EN] && !tx_empty;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_dout;
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = TX_START;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_RESET;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // ---------------- RX FSM ----------------
    assign rx_src  = ctrl_q[CTRL_LOOPBACK] ? tx_line : uart_rx_pin;
    assign rx_fall = rx_prev_q && !rx_sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_div_d   = div_q;
                    rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync2_q) rx_state_d = RX_IDLE;   // false start
                    else begin
                        rx_cnt_d   = rx_div_q - 16'd1;
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = rx_div_q - 16'd1;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    rx_push    = rx_sync2_q;
                    frame_set  = !rx_sync2_q;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        if (!ctrl_q[CTRL_RX_EN]) begin
            rx_state_d = RX_IDLE;
            rx_push    = 1'b0;
            frame_set  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_RESET;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync1_q <= rx_src;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF0140;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmio_read = 1'b0;
    logic        mmio_write = 1'b0;
    logic [31:0] mmio_addr = '0;
    logic [31:0] mmio_write_data = '0;
    logic        mmio_work, mmio_done, uart_tx_pin, irq;
    logic [31:0] mmio_read_data;
    logic        uart_rx_pin = 1'b1;

    int checks = 0;
    int errors = 0;

    mmio_uart_ctrl #(
        .BASE_ADDR(BASE),
        .TX_DEPTH (16),
        .RX_DEPTH (16),
        .DIV_RESET(16'd16)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .mmio_read      (mmio_read),
        .mmio_write     (mmio_write),
        .mmio_addr      (mmio_addr),
        .mmio_write_data(mmio_write_data),
        .mmio_work      (mmio_work),
        .mmio_done      (mmio_done),
        .mmio_read_data (mmio_read_data),
        .uart_rx_pin    (uart_rx_pin),
        .uart_tx_pin    (uart_tx_pin),
        .irq            (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        @(negedge sys_clk);
        mmio_write = 1'b1;
        mmio_addr = BASE + {27'd0, idx, 2'b00};
        mmio_write_data = data;
        @(negedge sys_clk);
        mmio_write = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] data;
        @(negedge sys_clk);
        mmio_read = 1'b1;
        mmio_addr = BASE + {27'd0, idx, 2'b00};
        @(negedge sys_clk);
        mmio_read = 1'b0;
        data = mmio_read_data;
        @(negedge sys_clk);
        chk(tag, data, exp);
    endtask

    task automatic wait_pin(input string tag, input logic val, input int bound);
        int n = 0;
        while (uart_tx_pin !== val && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, {31'd0, uart_tx_pin}, {31'd0, val});
    endtask

    task automatic run_len(input logic val, input int bound, output int n);
        n = 0;
        while (uart_tx_pin === val && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        @(negedge sys_clk);
        uart_rx_pin = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            repeat (16) @(negedge sys_clk);
        end
        uart_rx_pin = stop;
        repeat (16) @(negedge sys_clk);
        uart_rx_pin = 1'b1;
        repeat (32) @(negedge sys_clk);
    endtask

    initial begin
        logic [7:0] txb;
        int n;

        // ---- reset ----
        repeat (3) @(negedge sys_clk);
        chk("rst_tx_pin", {31'd0, uart_tx_pin}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_done", {31'd0, mmio_done}, 32'd0);
        chk("rst_rdata", mmio_read_data, 32'd0);
        rst_n = 1'b1;

        // STATUS read held for two cycles: done at N+1, low at N+2
        @(negedge sys_clk);
        mmio_read = 1'b1;
        mmio_addr = BASE;
        #1 chk("work_hit", {31'd0, mmio_work}, 32'd1);
        @(negedge sys_clk);
        chk("status_done_n1", {31'd0, mmio_done}, 32'd1);
        chk("status_reset", mmio_read_data, 32'h4);
        @(negedge sys_clk);
        chk("status_done_n2", {31'd0, mmio_done}, 32'd0);
        chk("rdata_idle_zero", mmio_read_data, 32'd0);
        mmio_read = 1'b0;
        mmio_addr = BASE + 32'h20;
        mmio_read = 1'b1;
        #1 chk("work_miss", {31'd0, mmio_work}, 32'd0);
        mmio_read = 1'b0;

        rd_chk("ctrl_reset", 3'd3, 32'h3);
        rd_chk("baud_reset", 3'd4, 32'd16);
        bus_write(3'd6, 32'hFFFF_FFFF);
        rd_chk("reg6_zero", 3'd6, 32'd0);

        // ---- TX 0x55 ----
        bus_write(3'd2, 32'h55);
        wait_pin("tx_start_fall", 1'b0, 40);
        repeat (8) @(negedge sys_clk);
        chk("tx_start_bit", {31'd0, uart_tx_pin}, 32'd0);
        txb = 8'h55;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge sys_clk);
            chk($sformatf("tx_bit%0d", i), {31'd0, uart_tx_pin}, {31'd0, txb[i]});
        end
        repeat (16) @(negedge sys_clk);
        chk("tx_stop_bit", {31'd0, uart_tx_pin}, 32'd1);
        repeat (16) @(negedge sys_clk);
        rd_chk("status_after_tx", 3'd0, 32'h4);

        // ---- loopback ----
        bus_write(3'd3, 32'h13);
        bus_write(3'd2, 32'hA5);
        bus_write(3'd2, 32'h3C);
        repeat (20) @(negedge sys_clk);
        chk("loopback_pin_high", {31'd0, uart_tx_pin}, 32'd1);
        repeat (400) @(negedge sys_clk);
        rd_chk("lb_status", 3'd0, 32'h5);
        rd_chk("lb_rx0", 3'd1, 32'hA5);
        rd_chk("lb_rx1", 3'd1, 32'h3C);
        rd_chk("lb_rx_empty", 3'd1, 32'h0);
        rd_chk("lb_status_empty", 3'd0, 32'h4);

        // ---- TX overflow ----
        bus_write(3'd3, 32'h02);
        for (int i = 0; i < 17; i++) bus_write(3'd2, 32'(i));
        rd_chk("ovf_status", 3'd0, 32'h88);
        chk("ovf_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd5, 32'h80);
        rd_chk("ovf_cleared", 3'd0, 32'h08);
        chk("ovf_irq_clear", {31'd0, irq}, 32'd0);
        bus_write(3'd3, 32'h03);
        repeat (16 * 160 + 60) @(negedge sys_clk);
        rd_chk("drained", 3'd0, 32'h4);

        // ---- RX from pin ----
        drive_rx(8'h96, 1'b1);
        rd_chk("rx_status", 3'd0, 32'h5);
        rd_chk("rx_byte", 3'd1, 32'h96);
        drive_rx(8'h5A, 1'b0);
        rd_chk("frame_err_status", 3'd0, 32'h44);
        chk("frame_err_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd5, 32'h40);
        rd_chk("frame_err_clear", 3'd0, 32'h4);
        @(negedge sys_clk);
        uart_rx_pin = 1'b0;
        repeat (2) @(negedge sys_clk);
        uart_rx_pin = 1'b1;
        repeat (200) @(negedge sys_clk);
        rd_chk("glitch_ignored", 3'd0, 32'h4);

        // ---- BAUD_DIV change mid-frame ----
        bus_write(3'd2, 32'hFF);
        bus_write(3'd2, 32'hFF);
        bus_write(3'd4, 32'd2);
        rd_chk("baud_clamped", 3'd4, 32'd4);
        wait_pin("f1_start_end", 1'b1, 40);
        run_len(1'b1, 300, n);
        chk("f1_high_len", 32'(n), 32'd144);
        run_len(1'b0, 50, n);
        chk("f2_start_len", 32'(n), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
